// File: rtl/td4_program_memory.sv
// TD4 instruction-fetch stage: 16-byte flop program store, pin-driven loader and
// the exec_mode strobe generator (manual step button or programmable divider).
module td4_program_memory #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_mode,
    input  logic             load_strobe,
    input  logic [7:0]       load_data,
    input  logic             step_btn,
    input  logic [DIV_W-1:0] step_div,
    input  logic [3:0]       pc,
    output logic [3:0]       opcode,
    output logic [3:0]       immediate,
    output logic             exec_mode,
    output logic [3:0]       load_addr,
    output logic             running
);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic             mode_p1;
    logic             mode_p2;
    logic             strobe_p1;
    logic             strobe_p2;
    logic             strobe_p3;
    logic             step_p1;
    logic             step_p2;
    logic             step_p3;

    logic             mode_sync;
    logic             strobe_edge;
    logic             step_edge;

    logic             wr_en;
    logic             run_active;
    logic             leave_run;

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_cnt_nxt;
    logic             exec_nxt;

    logic [7:0]       mem [16];
    logic [7:0]       rd_byte;

    // Pin synchronisers: p1 -> p2 is the metastability pair, p3 is the edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_p1   <= 1'b0;
            mode_p2   <= 1'b0;
            strobe_p1 <= 1'b0;
            strobe_p2 <= 1'b0;
            strobe_p3 <= 1'b0;
            step_p1   <= 1'b0;
            step_p2   <= 1'b0;
            step_p3   <= 1'b0;
        end else begin
            mode_p1   <= load_mode;
            mode_p2   <= mode_p1;
            strobe_p1 <= load_strobe;
            strobe_p2 <= strobe_p1;
            strobe_p3 <= strobe_p2;
            step_p1   <= step_btn;
            step_p2   <= step_p1;
            step_p3   <= step_p2;
        end
    end

    assign mode_sync   = mode_p2;
    assign strobe_edge = strobe_p2 & ~strobe_p3;
    assign step_edge   = step_p2 & ~step_p3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: if (!mode_sync) state_nxt = ST_RUN;
            ST_RUN:  if (mode_sync)  state_nxt = ST_LOAD;
            default: state_nxt = ST_LOAD;
        endcase
    end

    // A strobe edge in the LOAD->RUN cycle is still written; RUN ignores strobes
    always_comb begin
        running    = 1'b0;
        wr_en      = 1'b0;
        run_active = 1'b0;
        leave_run  = 1'b0;
        case (state)
            ST_LOAD: begin
                wr_en = strobe_edge;
            end
            ST_RUN: begin
                running    = 1'b1;
                run_active = ~mode_sync;
                leave_run  = mode_sync;
            end
            default: begin
                running = 1'b0;
            end
        endcase
    end

    // Step source: button edge when step_div is 0, otherwise an N+1 cycle divider
    always_comb begin
        div_cnt_nxt = '0;
        exec_nxt    = 1'b0;
        if (run_active) begin
            if (step_div == '0) begin
                exec_nxt = step_edge;
            end else if (div_cnt == step_div) begin
                exec_nxt = 1'b1;
            end else if (div_cnt > step_div) begin
                div_cnt_nxt = '0;
            end else begin
                div_cnt_nxt = div_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            exec_mode <= 1'b0;
        end else begin
            div_cnt   <= div_cnt_nxt;
            exec_mode <= exec_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_addr <= '0;
        end else if (wr_en) begin
            load_addr <= load_addr + 4'd1;
        end else if (leave_run) begin
            load_addr <= '0;
        end
    end

    // Program store is cleared by reset so an aborted load never leaves stale code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem[load_addr] <= load_data;
        end
    end

    assign rd_byte   = mem[pc];
    assign opcode    = rd_byte[7:4];
    assign immediate = rd_byte[3:0];

endmodule

// File: tb/tb_td4_program_memory.sv
// Self-checking bench for td4_program_memory: randomized loads and divider settings
// compared against a byte-array program model and closed-form pulse schedules.
module tb_td4_program_memory;

    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             load_mode;
    logic             load_strobe;
    logic [7:0]       load_data;
    logic             step_btn;
    logic [DIV_W-1:0] step_div;
    logic [3:0]       pc;
    logic [3:0]       opcode;
    logic [3:0]       immediate;
    logic             exec_mode;
    logic [3:0]       load_addr;
    logic             running;

    int               checks = 0;
    int               errors = 0;
    logic [7:0]       mem_m [16];
    int               addr_m = 0;

    td4_program_memory #(.DIV_W(DIV_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_mode  (load_mode),
        .load_strobe(load_strobe),
        .load_data  (load_data),
        .step_btn   (step_btn),
        .step_div   (step_div),
        .pc         (pc),
        .opcode     (opcode),
        .immediate  (immediate),
        .exec_mode  (exec_mode),
        .load_addr  (load_addr),
        .running    (running)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [7:0] b);
        mem_m[addr_m] = b;
        addr_m = (addr_m + 1) % 16;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        addr_m = 0;
    endtask

    task automatic pulse_strobe(input logic [7:0] b);
        load_data   = b;
        load_strobe = 1'b1;
        tick();
        tick();
        load_strobe = 1'b0;
        tick();
        tick();
        model_write(b);
    endtask

    task automatic go_run();
        load_mode = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            tick();
            checks++;
            if (running !== (t == 3)) begin
                errors++;
                $display("FAIL go_run t=%0d: running=%b expected %b", t, running, (t == 3));
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; load_mode = 1'b1; load_strobe = 1'b0; load_data = 8'h00;
        step_btn = 1'b0; step_div = '0; pc = 4'd0;
        model_clear();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (running !== 1'b0 || exec_mode !== 1'b0 || load_addr !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: running=%b exec=%b addr=%0d expected 0 0 0", running, exec_mode, load_addr);
        end
        for (int i = 0; i < 16; i++) begin
            pc = 4'(i);
            #1;
            checks++;
            if ({opcode, immediate} !== 8'h00) begin
                errors++;
                $display("FAIL reset_mem pc=%0d: got %02h expected 00", i, {opcode, immediate});
            end
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (6) tick();
        checks++;
        if (running !== 1'b0 || load_addr !== 4'd0 || exec_mode !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: running=%b addr=%0d exec=%b expected 0 0 0", running, load_addr, exec_mode);
        end
    endtask

    task automatic test_load_program();
        for (int i = 0; i < 16; i++) begin
            pulse_strobe(8'(i));
            checks++;
            if (load_addr !== 4'(addr_m)) begin
                errors++;
                $display("FAIL load_addr i=%0d: got %0d expected %0d", i, load_addr, addr_m);
            end
        end
        go_run();
        for (int i = 0; i < 16; i++) begin
            pc = 4'(i);
            #1;
            checks++;
            if ({opcode, immediate} !== mem_m[i]) begin
                errors++;
                $display("FAIL program_read pc=%0d: got %02h expected %02h", i, {opcode, immediate}, mem_m[i]);
            end
        end
    endtask

    task automatic test_step_manual();
        int pulses = 0;
        step_div = '0;
        tick();
        for (int p = 0; p < 3; p++) begin
            step_btn = 1'b1;
            for (int t = 1; t <= 8; t++) begin
                if (t == 5) step_btn = 1'b0;
                tick();
                if (exec_mode === 1'b1) pulses++;
                checks++;
                if (exec_mode !== (t == 3)) begin
                    errors++;
                    $display("FAIL step_press p=%0d t=%0d: exec=%b expected %b", p, t, exec_mode, (t == 3));
                end
            end
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL step_count: got %0d pulses expected 3", pulses);
        end
        step_btn = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            checks++;
            if (exec_mode !== (t == 3)) begin
                errors++;
                $display("FAIL step_held t=%0d: exec=%b expected %b", t, exec_mode, (t == 3));
            end
        end
        step_btn = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            tick();
            checks++;
            if (exec_mode !== 1'b0) begin
                errors++;
                $display("FAIL step_release t=%0d: exec=%b expected 0", t, exec_mode);
            end
        end
    endtask

    task automatic test_divider();
        int pulses = 0;
        step_div = 8'd3;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (exec_mode === 1'b1) pulses++;
            checks++;
            if (exec_mode !== (t % 4 == 0)) begin
                errors++;
                $display("FAIL div3 t=%0d: exec=%b expected %b", t, exec_mode, (t % 4 == 0));
            end
        end
        checks++;
        if (pulses != 10) begin
            errors++;
            $display("FAIL div3_count: got %0d pulses expected 10", pulses);
        end
        repeat (3) tick();
        step_div = 8'd1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            checks++;
            if (exec_mode !== (t >= 3 && t % 2 == 1)) begin
                errors++;
                $display("FAIL div_lower t=%0d: exec=%b expected %b", t, exec_mode, (t >= 3 && t % 2 == 1));
            end
        end
    endtask

    task automatic test_random_divider();
        int n;
        step_div = '0;
        tick();
        tick();
        n = $urandom_range(2, 9);
        step_div = 8'(n);
        for (int t = 1; t <= 4 * (n + 1); t++) begin
            tick();
            checks++;
            if (exec_mode !== (t % (n + 1) == 0)) begin
                errors++;
                $display("FAIL div_rand n=%0d t=%0d: exec=%b expected %b", n, t, exec_mode, (t % (n + 1) == 0));
            end
        end
        step_div = '0;
        tick();
    endtask

    task automatic test_run_to_load();
        step_div = '0;
        tick();
        tick();
        step_div = 8'd1;
        tick();
        checks++;
        if (exec_mode !== 1'b0) begin
            errors++;
            $display("FAIL r2l_pre: exec=%b expected 0", exec_mode);
        end
        load_mode = 1'b1;
        tick();
        checks++;
        if (exec_mode !== 1'b1) begin
            errors++;
            $display("FAIL r2l_pulse: exec=%b expected 1", exec_mode);
        end
        tick();
        checks++;
        if (exec_mode !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("FAIL r2l_mid: exec=%b running=%b expected 0 1", exec_mode, running);
        end
        tick();
        addr_m = 0;
        checks++;
        if (exec_mode !== 1'b0 || running !== 1'b0 || load_addr !== 4'd0) begin
            errors++;
            $display("FAIL r2l_entry: exec=%b running=%b addr=%0d expected 0 0 0", exec_mode, running, load_addr);
        end
        for (int t = 1; t <= 4; t++) begin
            tick();
            checks++;
            if (exec_mode !== 1'b0) begin
                errors++;
                $display("FAIL r2l_load t=%0d: exec=%b expected 0", t, exec_mode);
            end
        end
        step_div = '0;
    endtask

    task automatic test_load_latency();
        logic [7:0] old_b;
        old_b = mem_m[0];
        pc = 4'd0;
        load_data = 8'hC5;
        load_strobe = 1'b1;
        for (int t = 1; t <= 2; t++) begin
            tick();
            checks++;
            if ({opcode, immediate} !== old_b || load_addr !== 4'd0) begin
                errors++;
                $display("FAIL latency_early t=%0d: mem0=%02h addr=%0d expected %02h 0", t, {opcode, immediate}, load_addr, old_b);
            end
        end
        tick();
        checks++;
        if ({opcode, immediate} !== 8'hC5 || load_addr !== 4'd1) begin
            errors++;
            $display("FAIL latency_write: mem0=%02h addr=%0d expected c5 1", {opcode, immediate}, load_addr);
        end
        load_strobe = 1'b0;
        tick();
        tick();
        model_write(8'hC5);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 17; i++) pulse_strobe(8'(8'hA0 + i));
        checks++;
        if (load_addr !== 4'(addr_m)) begin
            errors++;
            $display("FAIL wrap_addr: got %0d expected %0d", load_addr, addr_m);
        end
        for (int i = 0; i < 16; i++) begin
            pc = 4'(i);
            #1;
            checks++;
            if ({opcode, immediate} !== mem_m[i]) begin
                errors++;
                $display("FAIL wrap_mem pc=%0d: got %02h expected %02h", i, {opcode, immediate}, mem_m[i]);
            end
        end
    endtask

    task automatic test_random_program();
        int n;
        n = $urandom_range(1, 20);
        for (int i = 0; i < n; i++) pulse_strobe(8'($urandom));
        checks++;
        if (load_addr !== 4'(addr_m)) begin
            errors++;
            $display("FAIL rand_addr: got %0d expected %0d", load_addr, addr_m);
        end
        for (int i = 0; i < 16; i++) begin
            pc = 4'(i);
            #1;
            checks++;
            if ({opcode, immediate} !== mem_m[i]) begin
                errors++;
                $display("FAIL rand_mem pc=%0d: got %02h expected %02h", i, {opcode, immediate}, mem_m[i]);
            end
        end
        go_run();
        for (int i = 0; i < 16; i++) begin
            pc = 4'($urandom_range(0, 15));
            #3;
            checks++;
            if ({opcode, immediate} !== mem_m[pc]) begin
                errors++;
                $display("FAIL rand_pc pc=%0d: got %02h expected %02h", pc, {opcode, immediate}, mem_m[pc]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int  n;
        bit  found = 0;
        step_div = 8'd1;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (exec_mode === 1'b1) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midrun_pulse: exec_mode never went high within 10 cycles");
        end
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        checks++;
        if (exec_mode !== 1'b0 || running !== 1'b0 || load_addr !== 4'd0) begin
            errors++;
            $display("FAIL midrun_async: exec=%b running=%b addr=%0d expected 0 0 0", exec_mode, running, load_addr);
        end
        for (int i = 0; i < 16; i++) begin
            pc = 4'(i);
            #1;
            checks++;
            if ({opcode, immediate} !== 8'h00) begin
                errors++;
                $display("FAIL midrun_mem pc=%0d: got %02h expected 00", i, {opcode, immediate});
            end
        end
        n = $urandom_range(2, 5);
        step_div = 8'(n);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if (running !== 1'b0 || exec_mode !== 1'b0) begin
            errors++;
            $display("FAIL midrun_release: running=%b exec=%b expected 0 0", running, exec_mode);
        end
        for (int t = 1; t <= (n + 2) + 2 * (n + 1); t++) begin
            tick();
            if (t == 1) begin
                checks++;
                if (running !== 1'b1) begin
                    errors++;
                    $display("FAIL midrun_rerun: running=%b expected 1", running);
                end
            end
            checks++;
            if (exec_mode !== (t >= n + 2 && (t - (n + 2)) % (n + 1) == 0)) begin
                errors++;
                $display("FAIL midrun_div n=%0d t=%0d: exec=%b", n, t, exec_mode);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_program();
        test_step_manual();
        test_divider();
        test_random_divider();
        test_run_to_load();
        test_load_latency();
        go_run();
        test_run_to_load();
        test_wrap();
        test_random_program();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/td4_program_memory.md
Name: td4_program_memory

Overview:
Instruction-fetch stage feeding the TD4 execute core. It holds the 16-byte program in a flop array and loads it from external pins in LOAD mode. In RUN mode it presents opcode/immediate for the core's current pc and generates the one-cycle exec_mode strobe that advances the core, either from a manual step button or from a programmable clock divider.

Parameters:
DIV_W, 8, width of step_div and of the internal divider counter.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
load_mode  in  1  async pin; 1 = LOAD, 0 = RUN; 2-FF synchronised
load_strobe  in  1  async pin; rising edge writes one byte; 2-FF synchronised plus edge detect
load_data  in  8  byte to write, {opcode[3:0], immediate[3:0]}; quasi-static, not synchronised
step_btn  in  1  async pin; rising edge = one manual step; 2-FF synchronised plus edge detect
step_div  in  DIV_W  0 = manual stepping; N>0 = auto step every N+1 clk cycles
pc  in  4  current program counter from the execute core
opcode  out  4  mem[pc][7:4], combinational read
immediate  out  4  mem[pc][3:0], combinational read
exec_mode  out  1  registered one-cycle execute pulse to the core
load_addr  out  4  next write address
running  out  1  1 when the FSM is in RUN

Behaviour:
- Reset (async): mem[0..15]=8'h00 (ADD A,0, i.e. a NOP), FSM=LOAD, load_addr=0, divider counter=0, all synchroniser and edge flops=0, exec_mode=0, running=0.
- Synchronisers: each pin has s1->s2->s3; edge = s2 & ~s3. A pin rising before clk edge k produces an active edge term in the cycle after edge k+1. The resulting action takes effect at edge k+2 (3rd edge). Synced mode = s2 of load_mode.
- FSM LOAD:
  - exec_mode=0, running=0.
  - On strobe edge: mem[load_addr] <= load_data; load_addr <= load_addr+1 mod 16 (15 wraps to 0 and overwrites from address 0).
  - Synced mode=0 -> RUN next cycle. A strobe edge in that same cycle is still written (write takes priority, then transition).
- FSM RUN:
  - running=1; mem is read-only; strobe edges are ignored.
  - Synced mode=1 -> LOAD next cycle. On entry: load_addr=0, counter=0, exec_mode forced 0. Step/divider events in the transition cycle are dropped.
  - step_div==0: exec_mode=1 for exactly one cycle per synced step_btn edge; counter held at 0.
  - step_div==N>0: counter increments every cycle. When counter==N: exec_mode=1 next cycle and counter<=0. The pulse period is N+1 cycles.
  - If counter>N (step_div lowered on the fly): counter<=0 with no pulse.
  - step_btn edges are ignored while N>0.
  - Counter is held at 0 in LOAD.
- exec_mode is registered, never high two consecutive cycles except when N==0 and the button produces edges on consecutive cycles, which the edge detector cannot do. Max rate is therefore every other cycle for N=1; N=1 gives a 2-cycle period.
- opcode/immediate:
  - Zero-latency combinational read of mem[pc], so the core samples the instruction for its current pc on the same edge exec_mode is high.
  - pc changing after that edge updates the outputs within the same cycle.
  - Valid in both modes; in LOAD they reflect partially loaded contents.
- Reset asserted mid-load or mid-run aborts immediately. Memory is cleared; the program must be reloaded.

Test Plan:
- Load 16 bytes 0x00..0x0F via strobe, drop load_mode -> mem[i]=i; load_addr wraps to 0; running=1 three cycles after pin fall; opcode/immediate track pc 0..15 correctly.
- Pulse load_strobe high at edge k with load_data=0xC5 -> mem[0]==0xC5 observable only after edge k+2, not before; load_addr 0->1 at the same edge.
- RUN, step_div=0, three step_btn pulses (each high 4 cycles, low 4 cycles) -> exactly three exec_mode pulses, each 1 cycle wide; held-high button gives one pulse only.
- RUN, step_div=3 for 40 cycles -> exec_mode high every 4th cycle (10 pulses); then set step_div=1 while counter=3 -> counter clears with no pulse, then 2-cycle period.
- Write 17 bytes (0xA0..0xB0) -> mem[0]=0xB0 (overwritten), mem[1..15]=0xA1..0xAF; toggle RUN->LOAD -> load_addr=0 and no exec_mode pulse during the transition.
- Assert rst_n low mid-RUN while exec_mode pulsing -> exec_mode, running, load_addr, counter and all mem drop to 0 asynchronously; FSM in LOAD after release.
